// File: rtl/fft_bitrev_buffer.sv
// Reorders one FFT frame from bit-reversed arrival order to natural order.
// Single buffer: the frame is fully written, then fully drained through a registered read and output stage.
module fft_bitrev_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_LOG    = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            point,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data_r,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  ready_out,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data_r,
    output logic [DATA_WIDTH-1:0] out_data_i,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int unsigned ADDR_W = MAX_LOG;
    localparam int unsigned CNT_W  = MAX_LOG + 1;
    localparam int unsigned DEPTH  = 1 << MAX_LOG;
    localparam int unsigned WORD_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [3:0]          p_q;
    logic [ADDR_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]    rd_cnt;
    logic [CNT_W-1:0]    frame_len;
    logic [ADDR_W-1:0]   last_idx;
    logic                point_ok;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic                rd_issue;
    logic                m_vld;
    logic                m_last;
    logic [WORD_W-1:0]   m_data;
    logic                out_adv;
    logic                m_adv;
    logic [WORD_W-1:0]   mem [DEPTH];

    // Reverse the low p bits of v; full-width reverse then shift the unused bits away.
    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v, input logic [3:0] p);
        logic [ADDR_W-1:0] r;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            r[i] = v[ADDR_W-1-i];
        end
        return r >> (4'(MAX_LOG) - p);
    endfunction

    assign frame_len = CNT_W'(1) << p_q;
    assign last_idx  = ADDR_W'(frame_len - CNT_W'(1));
    assign point_ok  = (point != 4'd0) && (point <= 4'(MAX_LOG));
    assign wr_en     = in_valid && ready_out;
    assign wr_addr   = (state == IDLE) ? '0 : bitrev(wr_cnt, p_q);
    assign out_adv   = !out_valid || out_ready;
    assign m_adv     = !m_vld || out_adv;
    assign rd_issue  = (state == DRAIN) && (rd_cnt < frame_len) && m_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_out = 1'b0;
        case (state)
            IDLE: begin
                ready_out = point_ok;
                if (in_valid && point_ok) state_nxt = FILL;
            end
            FILL: begin
                ready_out = 1'b1;
                if (in_valid && (wr_cnt == last_idx)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) ready_out = 1'b0;
    end

    // Write counter, read counter and the two-stage output pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q        <= 4'd1;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            m_vld      <= 1'b0;
            m_last     <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data_r <= '0;
            out_data_i <= '0;
        end else begin
            if (state == IDLE && wr_en) begin
                p_q    <= point;
                wr_cnt <= ADDR_W'(1);
            end else if (state == FILL && wr_en) begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
            end

            if (state != DRAIN) rd_cnt <= '0;
            else if (rd_issue)  rd_cnt <= rd_cnt + CNT_W'(1);

            if (m_adv)    m_vld  <= rd_issue;
            if (rd_issue) m_last <= (rd_cnt[ADDR_W-1:0] == last_idx);

            if (out_adv) begin
                out_valid <= m_vld;
                out_last  <= m_vld && m_last;
                if (m_vld) begin
                    out_data_r <= m_data[WORD_W-1:DATA_WIDTH];
                    out_data_i <= m_data[DATA_WIDTH-1:0];
                end
            end
        end
    end

    // Frame storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en)    mem[wr_addr] <= {in_data_r, in_data_i};
        if (rd_issue) m_data       <= mem[rd_cnt[ADDR_W-1:0]];
    end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Randomized bench for fft_bitrev_buffer against a bit-reverse permutation model.
module tb_fft_bitrev_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  point;
    logic        in_valid;
    logic [15:0] in_data_r, in_data_i;
    logic        ready_out, out_valid, out_last, out_ready;
    logic [15:0] out_data_r, out_data_i;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] got_r[$];
    logic [15:0] got_i[$];
    logic        got_l[$];
    logic [15:0] src_r[$];
    logic [15:0] src_i[$];
    int stall_bad, drain_to, first_v, last_v, nvalid;

    fft_bitrev_buffer #(.DATA_WIDTH(16), .MAX_LOG(13)) dut (
        .clk(clk), .rst(rst), .point(point), .in_valid(in_valid),
        .in_data_r(in_data_r), .in_data_i(in_data_i), .ready_out(ready_out),
        .out_valid(out_valid), .out_data_r(out_data_r), .out_data_i(out_data_i),
        .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic int rev(input int v, input int p);
        int r = 0;
        for (int b = 0; b < p; b++) r = r * 2 + ((v >> b) & 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic make_src(input int n, input int base);
        src_r.delete();
        src_i.delete();
        for (int k = 0; k < n; k++) begin
            src_r.push_back((base >= 0) ? 16'(base + k) : 16'($urandom));
            src_i.push_back(16'($urandom));
        end
    endtask

    task automatic send_frame(input int p);
        point = 4'(p);
        for (int k = 0; k < src_r.size(); k++) begin
            in_valid  = 1'b1;
            in_data_r = src_r[k];
            in_data_i = src_i[k];
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Collect n transfers; mode 0 keeps out_ready high, mode 1 asserts it every third cycle.
    task automatic drain(input int n, input int mode, input int budget);
        int cyc;
        logic held;
        logic [15:0] hr, hi;
        logic hl;
        got_r.delete(); got_i.delete(); got_l.delete();
        stall_bad = 0; drain_to = 0; nvalid = 0; first_v = -1; last_v = -1;
        cyc = 0; held = 1'b0; hr = '0; hi = '0; hl = 1'b0;
        while (got_r.size() < n) begin
            if (cyc >= budget) begin
                drain_to = 1;
                break;
            end
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (held && (!out_valid || out_data_r !== hr || out_data_i !== hi || out_last !== hl))
                stall_bad++;
            if (out_valid) begin
                nvalid++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (out_valid && out_ready) begin
                got_r.push_back(out_data_r);
                got_i.push_back(out_data_i);
                got_l.push_back(out_last);
            end
            held = out_valid && !out_ready;
            hr = out_data_r; hi = out_data_i; hl = out_last;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; point = 4'd3; in_valid = 1'b0; in_data_r = '0; in_data_i = '0; out_ready = 1'b1;
        repeat (3) tick();
        vectors++;
        if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_out); end
        vectors++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++; $display("FAIL reset_valid got v=%b l=%b exp 0 0", out_valid, out_last);
        end
        vectors++;
        if (out_data_r !== 16'h0 || out_data_i !== 16'h0) begin
            errors++; $display("FAIL reset_data got=%h/%h exp=0/0", out_data_r, out_data_i);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", ready_out); end
    endtask

    task automatic test_p3_order();
        make_src(8, 0);
        send_frame(3);
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL p3_lat0 got=%b exp=0", out_valid); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL p3_lat1 got=%b exp=0", out_valid); end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data_r !== 16'd0) begin
            errors++; $display("FAIL p3_lat2 got v=%b r=%0d exp v=1 r=0", out_valid, out_data_r);
        end
        drain(8, 0, 100);
        vectors++;
        if (drain_to != 0 || got_r.size() != 8) begin
            errors++; $display("FAIL p3_count got=%0d exp=8", got_r.size());
        end
        for (int k = 0; k < got_r.size(); k++) begin
            vectors++;
            if (got_r[k] !== src_r[rev(k, 3)] || got_i[k] !== src_i[rev(k, 3)] || got_l[k] !== (k == 7)) begin
                errors++;
                $display("FAIL p3_sample%0d got r=%0d i=%h l=%b exp r=%0d i=%h l=%b", k, got_r[k], got_i[k],
                         got_l[k], src_r[rev(k, 3)], src_i[rev(k, 3)], (k == 7));
            end
        end
        vectors++;
        if (nvalid != 8 || last_v - first_v + 1 != 8) begin
            errors++; $display("FAIL p3_bubbles got=%0d exp=8", nvalid);
        end
    endtask

    task automatic test_p1_min();
        make_src(2, 10);
        send_frame(1);
        drain(2, 0, 20);
        vectors++;
        if (drain_to != 0 || got_r.size() != 2) begin
            errors++; $display("FAIL p1_count got=%0d exp=2", got_r.size());
        end
        for (int k = 0; k < got_r.size(); k++) begin
            vectors++;
            if (got_r[k] !== 16'(10 + k) || got_i[k] !== src_i[k] || got_l[k] !== (k == 1)) begin
                errors++;
                $display("FAIL p1_sample%0d got r=%0d l=%b exp r=%0d l=%b", k, got_r[k], got_l[k], 10 + k, (k == 1));
            end
        end
        vectors++;
        if (out_valid !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL p1_return got v=%b rdy=%b exp v=0 rdy=1", out_valid, ready_out);
        end
    endtask

    task automatic test_p4_stall();
        make_src(16, -1);
        send_frame(4);
        drain(16, 1, 200);
        vectors++;
        if (drain_to != 0 || got_r.size() != 16) begin
            errors++; $display("FAIL p4_count got=%0d exp=16", got_r.size());
        end
        vectors++;
        if (stall_bad != 0) begin errors++; $display("FAIL p4_stall_hold got=%0d exp=0", stall_bad); end
        for (int k = 0; k < got_r.size(); k++) begin
            vectors++;
            if (got_r[k] !== src_r[rev(k, 4)] || got_i[k] !== src_i[rev(k, 4)] || got_l[k] !== (k == 15)) begin
                errors++;
                $display("FAIL p4_sample%0d got r=%h l=%b exp r=%h l=%b", k, got_r[k], got_l[k],
                         src_r[rev(k, 4)], (k == 15));
            end
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL p4_extra got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        make_src(8192, -1);
        send_frame(13);
        drain(8192, 0, 8300);
        vectors++;
        if (drain_to != 0 || got_r.size() != 8192) begin
            errors++; $display("FAIL p13_count got=%0d exp=8192", got_r.size());
        end
        for (int k = 0; k < got_r.size(); k++) begin
            vectors++;
            if (got_r[k] !== src_r[rev(k, 13)] || got_i[k] !== src_i[rev(k, 13)] || got_l[k] !== (k == 8191)) begin
                errors++;
                if (bad < 5)
                    $display("FAIL p13_sample%0d got r=%h i=%h l=%b exp r=%h i=%h l=%b", k, got_r[k], got_i[k],
                             got_l[k], src_r[rev(k, 13)], src_i[rev(k, 13)], (k == 8191));
                bad++;
            end
        end
        vectors++;
        if (nvalid != 8192 || last_v - first_v + 1 != 8192) begin
            errors++; $display("FAIL p13_consecutive got=%0d span=%0d exp=8192", nvalid, last_v - first_v + 1);
        end
    endtask

    task automatic test_reset_midframe();
        make_src(8, 0);
        send_frame(3);
        drain(5, 0, 50);
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || ready_out !== 1'b0) begin
            errors++; $display("FAIL abort got v=%b l=%b rdy=%b exp 0 0 0", out_valid, out_last, ready_out);
        end
        tick();
        rst = 1'b0;
        #1;
        make_src(4, 20);
        send_frame(2);
        drain(4, 0, 30);
        vectors++;
        if (drain_to != 0 || got_r.size() != 4) begin
            errors++; $display("FAIL p2_count got=%0d exp=4", got_r.size());
        end
        for (int k = 0; k < got_r.size(); k++) begin
            vectors++;
            if (got_r[k] !== 16'(20 + rev(k, 2)) || got_l[k] !== (k == 3)) begin
                errors++;
                $display("FAIL p2_sample%0d got r=%0d l=%b exp r=%0d l=%b", k, got_r[k], got_l[k], 20 + rev(k, 2), (k == 3));
            end
        end
    endtask

    task automatic test_point_range();
        int bad_pts[3] = '{0, 14, 15};
        foreach (bad_pts[j]) begin
            point = 4'(bad_pts[j]);
            in_valid = 1'b1;
            in_data_r = 16'hdead;
            #1;
            vectors++;
            if (ready_out !== 1'b0) begin
                errors++; $display("FAIL bad_point%0d got=%b exp=0", bad_pts[j], ready_out);
            end
            tick();
            vectors++;
            if (ready_out !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL bad_point%0d_hold got rdy=%b v=%b exp 0 0", bad_pts[j], ready_out, out_valid);
            end
        end
        in_valid = 1'b0;
        point = 4'd2;
        #1;
        vectors++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL point2_ready got=%b exp=1", ready_out); end
        tick();
        make_src(4, -1);
        send_frame(2);
        drain(4, 0, 30);
        vectors++;
        if (drain_to != 0 || got_r.size() != 4) begin
            errors++; $display("FAIL p2b_count got=%0d exp=4", got_r.size());
        end
        for (int k = 0; k < got_r.size(); k++) begin
            vectors++;
            if (got_r[k] !== src_r[rev(k, 2)] || got_i[k] !== src_i[rev(k, 2)]) begin
                errors++; $display("FAIL p2b_sample%0d got=%h exp=%h", k, got_r[k], src_r[rev(k, 2)]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_p3_order();
        test_p1_min();
        test_p4_stall();
        test_back_to_back();
        test_reset_midframe();
        test_point_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_buffer.md
Name: fft_bitrev_buffer

Overview:
- Receiving end of the FFT compute pipeline output.
- Accepts one frame of N = 2^point complex samples in bit-reversed order from the compute chain.
- Stores the frame in a single-port-per-side buffer and emits it in natural order to the downstream consumer (DMA write-back).
- Single buffer: a frame is fully written, then fully drained; there is no fill/drain overlap.

Parameters:
- DATA_WIDTH, 16, width of each real and imaginary component.
- MAX_LOG, 13, log2 of maximum FFT size; buffer depth is 2^MAX_LOG.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- point  input  4  log2 of frame size; valid range 1..MAX_LOG; latched on first sample of a frame.
- in_valid  input  1  sample present; upstream may assert it only in cycles where ready_out=1, and the sample transfers in that same cycle.
- in_data_r  input  DATA_WIDTH  real part.
- in_data_i  input  DATA_WIDTH  imaginary part.
- ready_out  output  1  block can accept a sample this cycle.
- out_valid  output  1  output sample valid.
- out_data_r  output  DATA_WIDTH  real part.
- out_data_i  output  DATA_WIDTH  imaginary part.
- out_last  output  1  high with the final sample (index N-1) of the frame.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid & out_ready.

Behaviour:
- Reset values: state IDLE; write and read counters 0; ready_out=0 while rst is high; out_valid=0; out_last=0; out_data=0. Buffer contents are not cleared.
- States are IDLE, FILL and DRAIN.
- IDLE:
  - ready_out = 1 iff point is in 1..MAX_LOG; otherwise ready_out = 0 and the block waits.
  - An in_valid cycle latches point as P (N = 2^P), writes the sample at address bitrev_P(0) = 0, sets wr_cnt = 1, and goes to FILL.
- FILL:
  - ready_out = 1.
  - Each in_valid writes to address bitrev_P(wr_cnt). bitrev_P reverses the low P bits; the upper bits are 0.
  - wr_cnt increments on each write. The write with wr_cnt = N-1 moves the state to DRAIN.
  - The point input is ignored until the next IDLE.
- DRAIN:
  - ready_out = 0.
  - The buffer is read sequentially, addresses 0..N-1.
  - The memory read is registered, and an output holding register gives full-throughput backpressure.
  - Last sample accepted on edge k → out_valid high after edge k+2, carrying address 0.
  - With out_ready held high, one sample is output per cycle with no bubbles.
  - When out_valid=1 and out_ready=0, out_data and out_last hold stable; no read pointer advances past the one-entry prefetch.
  - out_last = 1 exactly when the presented sample is address N-1.
  - The transfer of the out_last sample moves the state to IDLE; out_valid = 0 on the next cycle.
  - ready_out may rise in the cycle after the last transfer.
- Ordering invariant: out sample k equals the input sample whose arrival index is bitrev_P(k).
- No arithmetic is applied to the data; data passes through bit-exact.
- An asynchronous rst assertion in any state aborts the frame immediately: outputs go to their reset values and the partial frame is discarded.
- in_valid while ready_out = 0 is a protocol violation. The sample is ignored and nothing is written.
- P = 1 is the minimum frame: two samples, output order unchanged.

Test Plan:
- point=3, in_data_r = 0..7 in arrival order, out_ready=1 → out_data_r sequence 0,4,2,6,1,5,3,7; out_last only on 7; first out_valid 2 cycles after the last input edge.
- point=1, inputs r=10,11 → outputs 10,11; out_last on 11; return to IDLE with ready_out=1 one cycle after the last transfer.
- point=4, out_ready toggling 1,0,0,1,... → all 16 outputs appear in order 0,8,4,12,2,..., 15, with no duplicates or drops; data stable during stall cycles.
- point=13, 8192 random inputs with back-to-back in_valid and out_ready=1 → output matches the bit-reverse permutation; exactly 8192 consecutive out_valid cycles.
- rst pulsed after 5 of 8 outputs (point=3) → out_valid=0 immediately; a subsequent frame with point=2 and inputs 20..23 outputs 20,22,21,23.
- point=0 and point=14 in IDLE → ready_out stays 0; changing to point=2 → ready_out=1 on the same cycle.
